// File: rtl/exp5_pkg.sv
// rtl/exp5_pkg.sv - state codes and parameter defaults for the sonar control unit
package exp5_pkg;

    typedef enum logic [3:0] {
        ST_INICIAL            = 4'd0,
        ST_PREPARACAO         = 4'd1,
        ST_ESPERA_INTERVALO   = 4'd2,
        ST_ACIONA_MEDIDA      = 4'd3,
        ST_ESPERA_MEDIDA      = 4'd4,
        ST_TRANSMITE          = 4'd5,
        ST_ESPERA_TRANSMISSAO = 4'd6,
        ST_PROXIMO_CARACTERE  = 4'd7,
        ST_PROXIMO_ANGULO     = 4'd8
    } estado_t;

    localparam int MAX_TENTATIVAS_DEF = 3;
    localparam int N_INTERVALOS_DEF   = 1;

endpackage

// File: rtl/exp5_uc.sv
// rtl/exp5_uc.sv - sonar sweep control unit: interval wait, measure with retry, frame transmit, servo step
module exp5_uc
    import exp5_pkg::*;
#(
    parameter int MAX_TENTATIVAS = MAX_TENTATIVAS_DEF,
    parameter int N_INTERVALOS   = N_INTERVALOS_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ligar,
    input  logic       tick_intervalo,
    input  logic       pronto_medida,
    input  logic       timeout_echo,
    input  logic       pronto_transmissao,
    input  logic       fim_serial,
    input  logic       fim_posicao,
    output logic       zera,
    output logic       medir,
    output logic       conta_timeout_echo,
    output logic       partida_serial,
    output logic       conta_ascii,
    output logic       conta_angulo,
    output logic       pronto,
    output logic       erro_medida,
    output logic [3:0] db_estado
);

    localparam logic [2:0] TENT_LIM = 3'(MAX_TENTATIVAS - 1);
    localparam logic [3:0] INT_LIM  = 4'(N_INTERVALOS - 1);

    estado_t    estado_q, estado_d;
    logic [2:0] tentativas_q, tentativas_d;
    logic [3:0] intervalos_q, intervalos_d;
    logic       erro_q, erro_d;
    logic       ultimo_q, ultimo_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q     <= ST_INICIAL;
            tentativas_q <= 3'd0;
            intervalos_q <= 4'd0;
            erro_q       <= 1'b0;
            ultimo_q     <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            tentativas_q <= tentativas_d;
            intervalos_q <= intervalos_d;
            erro_q       <= erro_d;
            ultimo_q     <= ultimo_d;
        end
    end

    always_comb begin
        estado_d           = estado_q;
        tentativas_d       = tentativas_q;
        intervalos_d       = intervalos_q;
        erro_d             = erro_q;
        ultimo_d           = ultimo_q;
        zera               = 1'b0;
        medir              = 1'b0;
        conta_timeout_echo = 1'b0;
        partida_serial     = 1'b0;
        conta_ascii        = 1'b0;
        conta_angulo       = 1'b0;
        pronto             = 1'b0;

        case (estado_q)
            ST_INICIAL: begin
                if (ligar) estado_d = ST_PREPARACAO;
            end
            ST_PREPARACAO: begin
                zera         = 1'b1;
                tentativas_d = 3'd0;
                intervalos_d = 4'd0;
                erro_d       = 1'b0;
                estado_d     = ST_ESPERA_INTERVALO;
            end
            ST_ESPERA_INTERVALO: begin
                if (!ligar) begin
                    estado_d = ST_INICIAL;
                end else if (tick_intervalo) begin
                    if (intervalos_q == INT_LIM) begin
                        intervalos_d = 4'd0;
                        estado_d     = ST_ACIONA_MEDIDA;
                    end else begin
                        intervalos_d = intervalos_q + 4'd1;
                    end
                end
            end
            ST_ACIONA_MEDIDA: begin
                medir    = 1'b1;
                estado_d = ligar ? ST_ESPERA_MEDIDA : ST_INICIAL;
            end
            ST_ESPERA_MEDIDA: begin
                conta_timeout_echo = 1'b1;
                // A capture arriving with the timeout still counts as a good measurement.
                if (!ligar) begin
                    estado_d = ST_INICIAL;
                end else if (pronto_medida) begin
                    tentativas_d = 3'd0;
                    estado_d     = ST_TRANSMITE;
                end else if (timeout_echo) begin
                    if (tentativas_q < TENT_LIM) begin
                        tentativas_d = tentativas_q + 3'd1;
                        estado_d     = ST_ACIONA_MEDIDA;
                    end else begin
                        erro_d       = 1'b1;
                        tentativas_d = 3'd0;
                        estado_d     = ST_PROXIMO_ANGULO;
                    end
                end
            end
            ST_TRANSMITE: begin
                partida_serial = 1'b1;
                estado_d       = ST_ESPERA_TRANSMISSAO;
            end
            ST_ESPERA_TRANSMISSAO: begin
                if (pronto_transmissao) begin
                    ultimo_d = fim_serial;
                    estado_d = ST_PROXIMO_CARACTERE;
                end
            end
            ST_PROXIMO_CARACTERE: begin
                conta_ascii = 1'b1;
                // A started frame always finishes; ligar is only honoured after its last character.
                if (ultimo_q) estado_d = ligar ? ST_PROXIMO_ANGULO : ST_INICIAL;
                else          estado_d = ST_TRANSMITE;
            end
            ST_PROXIMO_ANGULO: begin
                conta_angulo = 1'b1;
                pronto       = fim_posicao;
                estado_d     = ligar ? ST_ESPERA_INTERVALO : ST_INICIAL;
            end
            default: begin
                estado_d = ST_INICIAL;
            end
        endcase
    end

    assign erro_medida = erro_q;
    assign db_estado   = estado_q;

endmodule

// File: tb/tb_exp5_uc.sv
// tb/tb_exp5_uc.sv - randomized bench for exp5_uc against a procedural sweep model
module tb_exp5_uc;

    localparam int MAXT = 3;
    localparam int NINT = 2;

    localparam logic [6:0] S_ZERA  = 7'b1000000;
    localparam logic [6:0] S_MEDIR = 7'b0100000;
    localparam logic [6:0] S_CTE   = 7'b0010000;
    localparam logic [6:0] S_PART  = 7'b0001000;
    localparam logic [6:0] S_ASCII = 7'b0000100;
    localparam logic [6:0] S_ANG   = 7'b0000011;

    logic clock = 1'b0;
    logic reset = 1'b1, ligar = 1'b0;
    logic tick_intervalo = 1'b0, pronto_medida = 1'b0, timeout_echo = 1'b0, pronto_transmissao = 1'b0;
    logic fim_serial, fim_posicao;
    logic zera, medir, conta_timeout_echo, partida_serial, conta_ascii, conta_angulo, pronto, erro_medida;
    logic [3:0] db_estado;

    int errors = 0;
    int checks = 0;

    exp5_uc #(.MAX_TENTATIVAS(MAXT), .N_INTERVALOS(NINT)) dut (
        .clock(clock), .reset(reset), .ligar(ligar), .tick_intervalo(tick_intervalo),
        .pronto_medida(pronto_medida), .timeout_echo(timeout_echo),
        .pronto_transmissao(pronto_transmissao), .fim_serial(fim_serial), .fim_posicao(fim_posicao),
        .zera(zera), .medir(medir), .conta_timeout_echo(conta_timeout_echo),
        .partida_serial(partida_serial), .conta_ascii(conta_ascii), .conta_angulo(conta_angulo),
        .pronto(pronto), .erro_medida(erro_medida), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    // datapath stand-in: ASCII and angle counters driven by the DUT strobes
    int ascii_cnt = 0, ang_cnt = 0;
    always @(posedge clock) begin
        if (reset || zera) begin
            ascii_cnt <= 0;
            ang_cnt   <= 0;
        end else begin
            if (conta_ascii)  ascii_cnt <= (ascii_cnt + 1) % 8;
            if (conta_angulo) ang_cnt   <= (ang_cnt + 1) % 8;
        end
    end
    assign fim_serial  = (ascii_cnt == 7);
    assign fim_posicao = (ang_cnt == 7);

    int n_zera = 0, n_medir = 0, n_part = 0, n_ascii = 0, n_ang = 0, n_pronto = 0, n_coinc = 0, ang_at_pronto = 0;
    always @(posedge clock) begin
        n_zera   <= n_zera + int'(zera);
        n_medir  <= n_medir + int'(medir);
        n_part   <= n_part + int'(partida_serial);
        n_ascii  <= n_ascii + int'(conta_ascii);
        n_ang    <= n_ang + int'(conta_angulo);
        n_pronto <= n_pronto + int'(pronto);
        n_coinc  <= n_coinc + int'(pronto && conta_angulo);
        if (pronto) ang_at_pronto <= n_ang + 1;
    end

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    // responders: interval timer, echo sensor and serial transmitter
    bit rnd = 1'b0;
    int echo_mode = 1;
    int tick_per = 10, tick_cnt = 9, echo_dly = 50, tx_dly = 20;
    int echo_cnt = 0, echo_kind = 0, tx_cnt = 0;
    initial begin : resp
        int r;
        forever begin
            @(posedge clock); #1;
            tick_intervalo = 1'b0; pronto_medida = 1'b0; timeout_echo = 1'b0; pronto_transmissao = 1'b0;
            if (tick_cnt == 0) begin
                tick_intervalo = 1'b1;
                tick_cnt = rnd ? int'($urandom_range(1, 11)) : tick_per - 1;
            end else tick_cnt--;
            if (echo_cnt > 0) begin
                echo_cnt--;
                if (echo_cnt == 0) begin
                    pronto_medida = (echo_kind != 1);
                    timeout_echo  = (echo_kind != 0);
                end
            end
            if (medir) begin
                echo_cnt = rnd ? int'($urandom_range(1, 40)) : echo_dly;
                if (echo_mode == 0) begin
                    r = int'($urandom_range(0, 9));
                    echo_kind = (r < 6) ? 0 : (r < 9) ? 1 : 2;
                end else echo_kind = (echo_mode == 1) ? 0 : 1;
            end
            if (tx_cnt > 0) begin
                tx_cnt--;
                if (tx_cnt == 0) pronto_transmissao = 1'b1;
            end
            if (partida_serial) tx_cnt = rnd ? int'($urandom_range(1, 25)) : tx_dly;
        end
    end

    // reference: the sweep narrative walked procedurally, one cyc() per clock
    bit model_go = 1'b0;
    bit m_erro = 1'b0;

    task automatic cyc(input logic [3:0] st, input logic [6:0] s);
        logic [11:0] e, a;
        @(negedge clock);
        e = {st, s[6:1], s[0] & fim_posicao, m_erro};
        a = {db_estado, zera, medir, conta_timeout_echo, partida_serial, conta_ascii, conta_angulo, pronto, erro_medida};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL cycle t=%0t: {state,zera,medir,cte,part,ascii,ang,pronto,erro} got %h required %h", $time, a, e);
        end
    endtask

    initial begin : model
        int nint, tries;
        bit last, ok, skip;
        wait (model_go);
        forever begin
            do cyc(4'd0, 7'd0); while (!ligar);
            cyc(4'd1, S_ZERA);
            m_erro = 1'b0; nint = 0; tries = 0; ok = 1'b1;
            while (ok) begin
                forever begin
                    cyc(4'd2, 7'd0);
                    if (!ligar) begin ok = 1'b0; break; end
                    if (tick_intervalo) begin
                        if (nint == NINT - 1) begin nint = 0; break; end
                        nint++;
                    end
                end
                if (!ok) break;
                skip = 1'b0;
                forever begin
                    cyc(4'd3, S_MEDIR);
                    if (!ligar) begin ok = 1'b0; break; end
                    do cyc(4'd4, S_CTE); while (ligar && !pronto_medida && !timeout_echo);
                    if (!ligar) begin ok = 1'b0; break; end
                    if (pronto_medida) begin tries = 0; break; end
                    if (tries < MAXT - 1) tries++;
                    else begin m_erro = 1'b1; tries = 0; skip = 1'b1; break; end
                end
                if (!ok) break;
                if (!skip) begin
                    do begin
                        cyc(4'd5, S_PART);
                        do cyc(4'd6, 7'd0); while (!pronto_transmissao);
                        last = fim_serial;
                        cyc(4'd7, S_ASCII);
                    end while (!last);
                    if (!ligar) break;
                end
                cyc(4'd8, S_ANG);
                if (!ligar) break;
            end
        end
    end

    task automatic wait_state(input logic [3:0] code, input string nm);
        int k = 0;
        while (db_estado !== code && k < 3000) begin @(negedge clock); k++; end
        check(nm, int'(db_estado), int'(code));
    endtask

    task automatic wait_ang(input int target, input string nm);
        int k = 0;
        while (n_ang < target && k < 5000) begin @(negedge clock); k++; end
        check(nm, (n_ang >= target) ? 1 : 0, 1);
    endtask

    initial begin : main
        int b_medir, b_part, b_ascii, b_ang, b_pronto, b_coinc, k;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_outputs", int'({zera, medir, conta_timeout_echo, partida_serial, conta_ascii, conta_angulo, pronto, erro_medida}), 0);
        check("reset_state", int'(db_estado), 0);
        @(posedge clock); #1;
        reset = 1'b0; ligar = 1'b1; model_go = 1'b1;
        @(negedge clock); check("start_idle", int'(db_estado), 0);
        @(negedge clock); check("start_prep", int'(db_estado), 1); check("zera_in_prep", int'(zera), 1);
        @(negedge clock); check("start_wait", int'(db_estado), 2); check("zera_single", n_zera, 1);

        // one good position: two ticks, 50-cycle echo, 20-cycle characters
        wait_ang(1, "first_position_done");
        check("first_medir", n_medir, 1);
        check("first_partida", n_part, 8);
        check("first_ascii", n_ascii, 8);
        check("first_angulo", n_ang, 1);
        check("first_back_wait", int'(db_estado), 2);

        // every echo times out: three tries, skip, error flag
        echo_mode = 2; echo_dly = 5;
        b_medir = n_medir; b_part = n_part; b_ang = n_ang;
        wait_ang(b_ang + 1, "skip_position_done");
        check("skip_medir", n_medir - b_medir, 3);
        check("skip_partida", n_part - b_part, 0);
        check("skip_angulo", n_ang - b_ang, 1);
        check("skip_erro", int'(erro_medida), 1);

        @(posedge clock); #1; ligar = 1'b0;
        wait_state(4'd0, "stop_to_idle");
        check("erro_sticky_idle", int'(erro_medida), 1);

        // full sweep of eight positions
        @(posedge clock); #1;
        ligar = 1'b1; echo_mode = 1; echo_dly = 3; tx_dly = 2; tick_per = 4;
        b_ang = n_ang; b_pronto = n_pronto; b_coinc = n_coinc;
        wait_ang(b_ang + 8, "sweep_done");
        check("sweep_pronto", n_pronto - b_pronto, 1);
        check("sweep_coinc", n_coinc - b_coinc, 1);
        check("sweep_pronto_on_8th", ang_at_pronto, b_ang + 8);
        check("sweep_erro_cleared", int'(erro_medida), 0);

        // stop while the third character is in flight
        tx_dly = 20;
        b_part = n_part; b_ascii = n_ascii; b_ang = n_ang; k = 0;
        while (!(n_part - b_part == 3 && db_estado == 4'd6) && k < 3000) begin @(negedge clock); k++; end
        check("abort_reached_char3", (n_part - b_part == 3) ? 1 : 0, 1);
        @(posedge clock); #1; ligar = 1'b0;
        wait_state(4'd0, "abort_to_idle");
        check("abort_partida", n_part - b_part, 8);
        check("abort_ascii", n_ascii - b_ascii, 8);
        check("abort_angulo", n_ang - b_ang, 0);

        // randomized run with occasional stop/start
        rnd = 1'b1; echo_mode = 0;
        @(posedge clock); #1; ligar = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            @(posedge clock); #1;
            if ($urandom_range(0, 299) == 0) ligar = ~ligar;
        end
        @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
